// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI-to-register-bus bridge: FSM states,
// command-byte bit positions and the default filler byte.
package spi_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } state_e;

    localparam int RW_BIT  = 7;
    localparam int INC_BIT = 6;

    localparam logic [7:0] DEFAULT_DUMMY = 8'hA5;

endpackage

// File: rtl/spi_reg_bridge.sv
// Decodes the SPI byte stream into single-cycle register-bus reads/writes
// with optional address auto-increment and a one-byte read pipeline.
module spi_reg_bridge
    import spi_bridge_pkg::*;
#(
    parameter int         ADDR_W     = 6,
    parameter logic [7:0] DUMMY_BYTE = DEFAULT_DUMMY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic              spi_done,
    input  logic [7:0]        spi_data_out,
    output logic [7:0]        spi_data_in,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_CMD   = ST_CMD;
    localparam logic [1:0] S_WRITE = ST_WRITE;
    localparam logic [1:0] S_READ  = ST_READ;

    logic [1:0]        r_state;
    logic              r_ss;
    logic              r_armed;
    logic              r_busy;
    logic              r_inc;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic              r_we;
    logic              r_re;
    logic              r_re_d;
    logic [7:0]        r_spi_data_in;

    logic [1:0] w_state_nxt;
    logic       w_done_cmd;
    logic       w_issue_wr;
    logic       w_issue_rd;

    assign w_done_cmd = spi_done && (r_state == S_CMD);
    assign w_issue_wr = spi_done && (r_state == S_WRITE);
    assign w_issue_rd = spi_done && ((r_state == S_READ) ||
                                     (w_done_cmd && !spi_data_out[RW_BIT]));

    // A byte completing in the same cycle that ss rises is still decoded;
    // the ss override only decides where the FSM lands afterwards.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!r_ss && r_armed) w_state_nxt = S_CMD;
            S_CMD:   if (spi_done) w_state_nxt = spi_data_out[RW_BIT] ? S_WRITE : S_READ;
            default: w_state_nxt = r_state;
        endcase
        if (r_ss) w_state_nxt = S_IDLE;
    end

    // r_armed blocks a frame that was already running when reset hit:
    // decoding resumes only after ss has been seen high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ss          <= 1'b0;
            r_armed       <= 1'b0;
            r_busy        <= 1'b0;
            r_inc         <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= 8'h00;
            r_we          <= 1'b0;
            r_re          <= 1'b0;
            r_re_d        <= 1'b0;
            r_spi_data_in <= DUMMY_BYTE;
        end else begin
            r_ss    <= ss;
            r_armed <= r_armed | r_ss;
            r_busy  <= !r_ss && r_armed;
            r_state <= w_state_nxt;
            r_we    <= w_issue_wr;
            r_re    <= w_issue_rd;
            r_re_d  <= r_re;

            if (w_done_cmd) begin
                r_addr <= spi_data_out[ADDR_W-1:0];
                r_inc  <= spi_data_out[INC_BIT];
            end else if ((r_we || r_re) && r_inc) begin
                r_addr <= r_addr + 1'b1;
            end

            if (w_issue_wr) r_wdata <= spi_data_out;

            // Read data lands two cycles after the strobe; stale data is
            // dropped once the frame has ended.
            if (w_state_nxt == S_IDLE) begin
                r_spi_data_in <= DUMMY_BYTE;
            end else if (r_re_d && (r_state == S_READ)) begin
                r_spi_data_in <= reg_rdata;
            end
        end
    end

    assign spi_data_in = r_spi_data_in;
    assign reg_addr    = r_addr;
    assign reg_wdata   = r_wdata;
    assign reg_we      = r_we;
    assign reg_re      = r_re;
    assign busy        = r_busy;
    assign dbg_state   = r_state;

endmodule
